pc_ddr_stream_bridge: RTL and testbench

- Generalised DDR-side interface for the ALFA-Pc octree pipeline.
- Fetches a point cloud from DDR in fixed-size bursts, unpacks each burst into per-axis coordinate vectors, and hands them to the BFS core with a valid/ready handshake.
- Independently buffers 64-bit occupancy-code words from the BFS core in a FIFO and writes them to DDR at sequential addresses.
- Replaces the single-state-input interface with self-sequenced read and write engines plus completion and status reporting.

---
 rtl/pc_ddr_stream_bridge_if.sv | 55 +++++
 rtl/pc_ddr_stream_bridge.sv | 202 ++++++++++++++++++++
 tb/tb_pc_ddr_stream_bridge.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_ddr_stream_bridge_if.sv
// Handshake and DDR-side bundle for pc_ddr_stream_bridge.
// Signal names are seen from the bridge: i_* go into the bridge and o_* come out of it.
interface pc_ddr_stream_bridge_if #(
  parameter int N       = 32,
  parameter int COORD_W = 16,
  parameter int WORD_W  = 64
);
  // Job control
  logic                   i_start;
  logic [31:0]            i_total_points;
  // Read engine
  logic                   o_initreadtxn;
  logic [31:0]            o_read_address;
  logic                   i_read_TxnDone;
  logic [WORD_W*N-1:0]    i_AMU_P;
  logic [COORD_W*N-1:0]   o_x_points;
  logic [COORD_W*N-1:0]   o_y_points;
  logic [COORD_W*N-1:0]   o_z_points;
  logic                   o_points_valid;
  logic [7:0]             o_points_count;
  logic                   i_points_ready;
  // Occupancy / write engine
  logic                   i_occ_valid;
  logic [63:0]            i_occ_data;
  logic                   o_occ_ready;
  logic                   i_flush;
  logic                   o_initwritetxn;
  logic [31:0]            o_write_address;
  logic [63:0]            o_write_payload;
  logic                   i_write_TxnDone;
  // Status
  logic [31:0]            o_points_read;
  logic [31:0]            o_words_written;
  logic                   o_busy;
  logic                   o_done;
  logic                   o_overflow;

  modport master (
    input  i_start, i_total_points, i_read_TxnDone, i_AMU_P, i_points_ready,
           i_occ_valid, i_occ_data, i_flush, i_write_TxnDone,
    output o_initreadtxn, o_read_address, o_x_points, o_y_points, o_z_points,
           o_points_valid, o_points_count, o_occ_ready, o_initwritetxn,
           o_write_address, o_write_payload, o_points_read, o_words_written,
           o_busy, o_done, o_overflow
  );

  modport slave (
    output i_start, i_total_points, i_read_TxnDone, i_AMU_P, i_points_ready,
           i_occ_valid, i_occ_data, i_flush, i_write_TxnDone,
    input  o_initreadtxn, o_read_address, o_x_points, o_y_points, o_z_points,
           o_points_valid, o_points_count, o_occ_ready, o_initwritetxn,
           o_write_address, o_write_payload, o_points_read, o_words_written,
           o_busy, o_done, o_overflow
  );
endinterface

// File: rtl/pc_ddr_stream_bridge.sv
// DDR-side bridge for the ALFA-Pc octree pipeline: bursts point batches in from DDR and
// streams buffered occupancy words back out, with job completion and status reporting.
module pc_ddr_stream_bridge #(
  parameter int          POINTS_PER_READ = 32,
  parameter int          COORD_W         = 16,
  parameter int          WORD_W          = 64,
  parameter logic [31:0] DDR_RD_BASE     = 32'h0E00_0000,
  parameter logic [31:0] DDR_WR_BASE     = 32'h0F00_0000,
  parameter int          WR_FIFO_DEPTH   = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  pc_ddr_stream_bridge_if.master   bus
);

  localparam int          N           = POINTS_PER_READ;
  localparam int          AW          = $clog2(WR_FIFO_DEPTH);
  localparam logic [31:0] RD_STRIDE   = 32'(N * WORD_W / 8);
  localparam logic [AW:0] FIFO_FULL_N = (AW + 1)'(WR_FIFO_DEPTH);

  typedef enum logic [2:0] {R_IDLE, R_REQ, R_WAIT, R_PRESENT, R_DONE} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_ISSUE, W_WAIT} wr_state_e;

  rd_state_e              rd_state_q;
  wr_state_e              wr_state_q;
  logic                   busy_q, done_q, overflow_q, flush_pending_q;
  logic [31:0]            remaining_q, rd_addr_q, points_read_q;
  logic                   initread_q, points_valid_q;
  logic [7:0]             count_q;
  logic [COORD_W*N-1:0]   x_q, y_q, z_q;
  logic [COORD_W*N-1:0]   x_d, y_d, z_d;
  logic                   initwrite_q;
  logic [31:0]            wr_addr_q, words_written_q;
  logic [63:0]            payload_q;

  logic [63:0]            fifo_mem [WR_FIFO_DEPTH];
  logic [AW:0]            wptr_q, rptr_q, fifo_cnt;
  logic                   fifo_full, fifo_empty, push, pop, overflow_set;
  logic                   start_acc, job_done;
  logic [7:0]             batch_cnt;
  logic                   unused_amu;

  assign fifo_cnt     = wptr_q - rptr_q;
  assign fifo_full    = (fifo_cnt == FIFO_FULL_N);
  assign fifo_empty   = (wptr_q == rptr_q);
  assign pop          = (wr_state_q == W_WAIT) && bus.i_write_TxnDone;
  // A pop on the same cycle frees the slot, so a full FIFO can still take the word.
  assign push         = bus.i_occ_valid && (!fifo_full || pop);
  assign overflow_set = bus.i_occ_valid && fifo_full && !pop;
  assign start_acc    = bus.i_start && !busy_q;
  assign job_done     = busy_q && flush_pending_q && fifo_empty &&
                        (wr_state_q == W_IDLE) && (rd_state_q == R_DONE);
  assign batch_cnt    = (remaining_q >= 32'(N)) ? 8'(N) : remaining_q[7:0];
  assign unused_amu   = ^bus.i_AMU_P;

  // Unpack the burst; lanes past the valid count are forced to zero.
  always_comb begin
    // NOTE: defaults first so every path assigns every bit and no latch is inferred.
    x_d = '0;
    y_d = '0;
    z_d = '0;
    for (int k = 0; k < N; k++) begin
      if (k < int'(batch_cnt)) begin
        x_d[k*COORD_W +: COORD_W] = bus.i_AMU_P[k*WORD_W +: COORD_W];
        y_d[k*COORD_W +: COORD_W] = bus.i_AMU_P[k*WORD_W + COORD_W +: COORD_W];
        z_d[k*COORD_W +: COORD_W] = bus.i_AMU_P[k*WORD_W + 2*COORD_W +: COORD_W];
      end
    end
  end

  // Job control and read engine.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      rd_state_q      <= R_IDLE;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      overflow_q      <= 1'b0;
      flush_pending_q <= 1'b0;
      remaining_q     <= '0;
      rd_addr_q       <= '0;
      points_read_q   <= '0;
      initread_q      <= 1'b0;
      points_valid_q  <= 1'b0;
      count_q         <= '0;
      x_q             <= '0;
      y_q             <= '0;
      z_q             <= '0;
    end else begin
      if (start_acc)         overflow_q <= 1'b0;
      else if (overflow_set) overflow_q <= 1'b1;

      if (start_acc)         flush_pending_q <= bus.i_flush;
      else if (job_done)     flush_pending_q <= 1'b0;
      else if (bus.i_flush)  flush_pending_q <= 1'b1;

      if (job_done) begin
        done_q     <= 1'b1;
        busy_q     <= 1'b0;
        rd_state_q <= R_IDLE;
      end else begin
        case (rd_state_q)
          R_IDLE: if (start_acc) begin
            busy_q        <= 1'b1;
            done_q        <= 1'b0;
            points_read_q <= '0;
            remaining_q   <= bus.i_total_points;
            rd_addr_q     <= DDR_RD_BASE;
            if (bus.i_total_points == '0) begin
              rd_state_q <= R_DONE;
            end else begin
              initread_q <= 1'b1;
              rd_state_q <= R_REQ;
            end
          end
          R_REQ: begin
            initread_q <= 1'b0;
            rd_state_q <= R_WAIT;
          end
          R_WAIT: if (bus.i_read_TxnDone) begin
            x_q            <= x_d;
            y_q            <= y_d;
            z_q            <= z_d;
            count_q        <= batch_cnt;
            points_valid_q <= 1'b1;
            rd_state_q     <= R_PRESENT;
          end
          R_PRESENT: if (bus.i_points_ready) begin
            points_valid_q <= 1'b0;
            points_read_q  <= points_read_q + 32'(count_q);
            remaining_q    <= remaining_q - 32'(count_q);
            if (remaining_q != 32'(count_q)) begin
              initread_q <= 1'b1;
              rd_addr_q  <= rd_addr_q + RD_STRIDE;
              rd_state_q <= R_REQ;
            end else begin
              rd_state_q <= R_DONE;
            end
          end
          R_DONE:  rd_state_q <= R_DONE;
          default: rd_state_q <= R_IDLE;
        endcase
      end
    end
  end

  // Write engine and FIFO pointers; runs independently of the read job.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      wr_state_q      <= W_IDLE;
      wptr_q          <= '0;
      rptr_q          <= '0;
      initwrite_q     <= 1'b0;
      wr_addr_q       <= '0;
      payload_q       <= '0;
      words_written_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;

      if (start_acc) words_written_q <= '0;
      else if (pop)  words_written_q <= words_written_q + 32'd1;

      case (wr_state_q)
        W_IDLE: if (!fifo_empty) begin
          initwrite_q <= 1'b1;
          wr_addr_q   <= DDR_WR_BASE + (words_written_q << 3);
          payload_q   <= fifo_mem[rptr_q[AW-1:0]];
          wr_state_q  <= W_ISSUE;
        end
        W_ISSUE: begin
          initwrite_q <= 1'b0;
          wr_state_q  <= W_WAIT;
        end
        W_WAIT:  if (bus.i_write_TxnDone) wr_state_q <= W_IDLE;
        default: wr_state_q <= W_IDLE;
      endcase
    end
  end

  // NOTE: storage is left unreset; the pointers alone decide which entries are live.
  always_ff @(posedge i_clk) begin
    if (i_rst && push) fifo_mem[wptr_q[AW-1:0]] <= bus.i_occ_data;
  end

  assign bus.o_initreadtxn   = initread_q;
  assign bus.o_read_address  = rd_addr_q;
  assign bus.o_x_points      = x_q;
  assign bus.o_y_points      = y_q;
  assign bus.o_z_points      = z_q;
  assign bus.o_points_valid  = points_valid_q;
  assign bus.o_points_count  = count_q;
  assign bus.o_occ_ready     = i_rst && !fifo_full;
  assign bus.o_initwritetxn  = initwrite_q;
  assign bus.o_write_address = wr_addr_q;
  assign bus.o_write_payload = payload_q;
  assign bus.o_points_read   = points_read_q;
  assign bus.o_words_written = words_written_q;
  assign bus.o_busy          = busy_q;
  assign bus.o_done          = done_q;
  assign bus.o_overflow      = overflow_q;

endmodule

// File: tb/tb_pc_ddr_stream_bridge.sv
// Directed bench for pc_ddr_stream_bridge: batch reads, unpack, occupancy writes,
// FIFO full/overflow, and reset in the middle of outstanding transactions.
module tb_pc_ddr_stream_bridge;
  localparam int N = 32;
  localparam int COORD_W = 16;
  localparam int WORD_W = 64;

  logic i_clk;
  logic i_rst;
  int   vectors = 0;
  int   miscompares = 0;

  pc_ddr_stream_bridge_if #(.N(N), .COORD_W(COORD_W), .WORD_W(WORD_W)) bus ();

  pc_ddr_stream_bridge dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus.master)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Point k: x = seed+k, y = seed+k+0x100, z = seed+k+0x200, top field filled with ones.
  function automatic logic [N*WORD_W-1:0] make_burst(input logic [15:0] seed);
    logic [N*WORD_W-1:0] b;
    logic [15:0] v;
    b = '0;
    for (int k = 0; k < N; k++) begin
      v = seed + 16'(k);
      b[k*WORD_W +: WORD_W] = {16'hFFFF, v + 16'h0200, v + 16'h0100, v};
    end
    return b;
  endfunction

  function automatic logic [63:0] dword(input int i);
    return 64'hA000_0000_0000_0000 + 64'(i);
  endfunction

  task automatic start_job(input logic [31:0] total);
    bus.i_start = 1'b1;
    bus.i_total_points = total;
    tick();
    bus.i_start = 1'b0;
  endtask

  task automatic wait_rd_req(input string tag, input logic [31:0] addr);
    for (int i = 0; i < 20 && !bus.o_initreadtxn; i++) tick();
    check({tag, "_pulse"}, bus.o_initreadtxn, 1);
    check({tag, "_addr"}, bus.o_read_address, addr);
  endtask

  // Called while the read request is showing; completes the burst one cycle later.
  task automatic read_burst(input logic [N*WORD_W-1:0] data);
    tick();
    bus.i_AMU_P = data;
    bus.i_read_TxnDone = 1'b1;
    tick();
    bus.i_read_TxnDone = 1'b0;
  endtask

  task automatic do_write(input string tag, input logic [31:0] addr, input logic [63:0] data,
                          input int gap);
    for (int i = 0; i < 20 && !bus.o_initwritetxn; i++) tick();
    check({tag, "_pulse"}, bus.o_initwritetxn, 1);
    check({tag, "_addr"}, bus.o_write_address, addr);
    check({tag, "_data"}, bus.o_write_payload, data);
    tick(gap);
    bus.i_write_TxnDone = 1'b1;
    tick();
    bus.i_write_TxnDone = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 20 && !bus.o_done; i++) tick();
    check({tag, "_done"}, bus.o_done, 1);
    check({tag, "_busy"}, bus.o_busy, 0);
  endtask

  initial begin
    i_rst = 1'b0;
    bus.i_start = 1'b0;
    bus.i_total_points = '0;
    bus.i_read_TxnDone = 1'b0;
    bus.i_AMU_P = '0;
    bus.i_points_ready = 1'b0;
    bus.i_occ_valid = 1'b0;
    bus.i_occ_data = '0;
    bus.i_flush = 1'b0;
    bus.i_write_TxnDone = 1'b0;
    tick(3);
    check("rst_busy", bus.o_busy, 0);
    check("rst_done", bus.o_done, 0);
    check("rst_valid", bus.o_points_valid, 0);
    check("rst_occ_ready", bus.o_occ_ready, 0);
    i_rst = 1'b1;
    tick();

    // ---- 70-point job: three batches, first one held for 10 cycles ----
    start_job(32'd70);
    check("jobA_busy", bus.o_busy, 1);
    wait_rd_req("rd0", 32'h0E00_0000);
    bus.i_AMU_P = '0;
    read_burst({{(N-6)*WORD_W{1'b0}}, 64'h0000_0003_0002_0001, {5*WORD_W{1'b0}}});
    check("b0_valid", bus.o_points_valid, 1);
    check("b0_count", bus.o_points_count, 32);
    check("b0_x5", bus.o_x_points[5*COORD_W +: COORD_W], 16'h0001);
    check("b0_y5", bus.o_y_points[5*COORD_W +: COORD_W], 16'h0002);
    check("b0_z5", bus.o_z_points[5*COORD_W +: COORD_W], 16'h0003);
    bus.i_AMU_P = '1;
    bus.i_start = 1'b1;
    bus.i_total_points = 32'd5;
    tick();
    bus.i_start = 1'b0;
    tick(9);
    check("hold_valid", bus.o_points_valid, 1);
    check("hold_count", bus.o_points_count, 32);
    check("hold_x5", bus.o_x_points[5*COORD_W +: COORD_W], 16'h0001);
    check("hold_z5", bus.o_z_points[5*COORD_W +: COORD_W], 16'h0003);
    check("hold_x0", bus.o_x_points[0 +: COORD_W], 16'h0000);
    check("hold_read", bus.o_points_read, 0);
    bus.i_points_ready = 1'b1;
    tick();
    check("b0_drop", bus.o_points_valid, 0);
    check("b0_read", bus.o_points_read, 32);
    wait_rd_req("rd1", 32'h0E00_0100);
    read_burst(make_burst(16'h1000));
    check("b1_count", bus.o_points_count, 32);
    check("b1_x31", bus.o_x_points[31*COORD_W +: COORD_W], 16'h101F);
    check("b1_z31", bus.o_z_points[31*COORD_W +: COORD_W], 16'h121F);
    wait_rd_req("rd2", 32'h0E00_0200);
    check("b1_read", bus.o_points_read, 64);
    read_burst(make_burst(16'h2000));
    check("b2_count", bus.o_points_count, 6);
    check("b2_x5", bus.o_x_points[5*COORD_W +: COORD_W], 16'h2005);
    check("b2_z5", bus.o_z_points[5*COORD_W +: COORD_W], 16'h2205);
    check("b2_x6", bus.o_x_points[6*COORD_W +: COORD_W], 16'h0000);
    check("b2_y31", bus.o_y_points[31*COORD_W +: COORD_W], 16'h0000);
    tick();
    check("b2_read", bus.o_points_read, 70);
    check("b2_drop", bus.o_points_valid, 0);
    check("rd_only_busy", bus.o_busy, 1);
    check("rd_only_done", bus.o_done, 0);

    // ---- Three occupancy words, TxnDone 4 cycles after each request, then flush ----
    bus.i_occ_valid = 1'b1;
    bus.i_occ_data = 64'h1111_2222_3333_4444;
    tick();
    bus.i_occ_data = 64'h5555_6666_7777_8888;
    tick();
    check("wr0_pulse", bus.o_initwritetxn, 1);
    check("wr0_addr", bus.o_write_address, 32'h0F00_0000);
    check("wr0_data", bus.o_write_payload, 64'h1111_2222_3333_4444);
    bus.i_occ_data = 64'h9999_AAAA_BBBB_CCCC;
    tick();
    bus.i_occ_valid = 1'b0;
    bus.i_flush = 1'b1;
    tick();
    bus.i_flush = 1'b0;
    tick();
    bus.i_write_TxnDone = 1'b1;
    tick();
    bus.i_write_TxnDone = 1'b0;
    check("wr0_count", bus.o_words_written, 1);
    check("wr0_not_done", bus.o_done, 0);
    do_write("wr1", 32'h0F00_0008, 64'h5555_6666_7777_8888, 3);
    do_write("wr2", 32'h0F00_0010, 64'h9999_AAAA_BBBB_CCCC, 3);
    check("wr2_count", bus.o_words_written, 3);
    check("wr2_not_done", bus.o_done, 0);
    tick();
    check("jobA_done", bus.o_done, 1);
    check("jobA_idle", bus.o_busy, 0);

    // ---- Fill the 8-deep FIFO with TxnDone withheld, then overflow it ----
    bus.i_points_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i == 7) check("ready_before_8th", bus.o_occ_ready, 1);
      if (i == 8) begin
        check("ready_after_8th", bus.o_occ_ready, 0);
        check("ovf_before_9th", bus.o_overflow, 0);
      end
      bus.i_occ_valid = 1'b1;
      bus.i_occ_data = dword(i);
      tick();
    end
    bus.i_occ_valid = 1'b0;
    check("ovf_set", bus.o_overflow, 1);
    check("full_ready", bus.o_occ_ready, 0);
    check("head_addr", bus.o_write_address, 32'h0F00_0018);
    check("head_data", bus.o_write_payload, dword(0));

    // ---- New job clears overflow; push and pop together while full ----
    start_job(32'd0);
    check("jobB_busy", bus.o_busy, 1);
    check("jobB_ovf_clr", bus.o_overflow, 0);
    check("jobB_words", bus.o_words_written, 0);
    bus.i_occ_valid = 1'b1;
    bus.i_occ_data = dword(9);
    bus.i_write_TxnDone = 1'b1;
    tick();
    bus.i_occ_valid = 1'b0;
    bus.i_write_TxnDone = 1'b0;
    check("pp_ready", bus.o_occ_ready, 0);
    check("pp_ovf", bus.o_overflow, 0);
    check("pp_words", bus.o_words_written, 1);
    for (int i = 1; i <= 8; i++)
      do_write("drain", 32'h0F00_0000 + 32'(i * 8), (i < 8) ? dword(i) : dword(9), 1);
    check("drain_words", bus.o_words_written, 9);
    check("drain_ready", bus.o_occ_ready, 1);
    bus.i_flush = 1'b1;
    tick();
    bus.i_flush = 1'b0;
    wait_done("jobB");

    // ---- Reset with both engines waiting on DDR ----
    bus.i_occ_valid = 1'b1;
    bus.i_occ_data = dword(85);
    tick();
    bus.i_occ_valid = 1'b0;
    start_job(32'd32);
    tick();
    i_rst = 1'b0;
    tick();
    check("mid_rst_busy", bus.o_busy, 0);
    check("mid_rst_done", bus.o_done, 0);
    check("mid_rst_initrd", bus.o_initreadtxn, 0);
    check("mid_rst_initwr", bus.o_initwritetxn, 0);
    check("mid_rst_rdaddr", bus.o_read_address, 0);
    check("mid_rst_wraddr", bus.o_write_address, 0);
    check("mid_rst_payload", bus.o_write_payload, 0);
    check("mid_rst_pread", bus.o_points_read, 0);
    check("mid_rst_words", bus.o_words_written, 0);
    check("mid_rst_count", bus.o_points_count, 0);
    check("mid_rst_ready", bus.o_occ_ready, 0);
    i_rst = 1'b1;
    bus.i_AMU_P = make_burst(16'h3000);
    bus.i_read_TxnDone = 1'b1;
    bus.i_write_TxnDone = 1'b1;
    tick();
    bus.i_read_TxnDone = 1'b0;
    bus.i_write_TxnDone = 1'b0;
    check("stale_valid", bus.o_points_valid, 0);
    check("stale_words", bus.o_words_written, 0);
    check("stale_initwr", bus.o_initwritetxn, 0);
    check("stale_busy", bus.o_busy, 0);
    check("stale_ready", bus.o_occ_ready, 1);
    start_job(32'd0);
    bus.i_flush = 1'b1;
    tick();
    bus.i_flush = 1'b0;
    wait_done("jobC");
    check("jobC_pread", bus.o_points_read, 0);
    check("jobC_initrd", bus.o_initreadtxn, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
